// File: rtl/bus_ctrl.sv
// Multiplexed 20-bit address / 16-bit data bus master: IDLE->ADDR->HOLD->DATA->RECOVER.
// Optional BUS_CTRL_EXT_WAIT_EN adds a bus_rdy input that stretches the last DATA cycle.
module bus_ctrl #(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        wr,
   input  logic        io,
   input  logic [19:0] addr,
   input  logic [15:0] wdata,
   output logic        ack,
   output logic        busy,
   output logic [15:0] rdata,
   output logic [19:0] ad_o,
   input  logic [15:0] ad_i,
   output logic        ad_oe_hi,
   output logic        ad_oe_lo,
   output logic        ale,
   output logic        oe_n,
   output logic        we_n,
   output logic        pio
`ifdef BUS_CTRL_EXT_WAIT_EN
   ,
   input  logic        bus_rdy
`endif
);

   localparam int unsigned ADDR_W = 20;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ADDR    = 3'd1,
      S_HOLD    = 3'd2,
      S_DATA    = 3'd3,
      S_RECOVER = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                wr_q, wr_d, io_q, io_d;
   logic [DATA_W-1:0]   rdata_d;
   logic [ADDR_W-1:0]   ad_o_d;
   logic                ack_d, busy_d, ale_d, oe_n_d, we_n_d, pio_d, oe_hi_d, oe_lo_d;
   logic                rdy_c, in_bus_c, in_data_c, in_tail_c;

`ifdef BUS_CTRL_EXT_WAIT_EN
   assign rdy_c = bus_rdy;
`else
   assign rdy_c = 1'b1;
`endif

   // Next state, capture registers and the output values for the state being entered
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      io_d    = io_q;
      rdata_d = rdata;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d  = addr;
               wdata_d = wdata;
               wr_d    = wr;
               io_d    = io;
               state_d = S_ADDR;
            end
         end
         S_ADDR: state_d = S_HOLD;
         S_HOLD: begin
            cnt_d   = CNT_W'(WAIT_STATES);
            state_d = S_DATA;
         end
         S_DATA: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (rdy_c) begin
               if (!wr_q) rdata_d = ad_i;
               state_d = S_RECOVER;
            end
         end
         S_RECOVER: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      in_bus_c  = (state_d != S_IDLE);
      in_data_c = (state_d == S_DATA);
      in_tail_c = in_data_c || (state_d == S_RECOVER);

      ale_d   = (state_d == S_ADDR);
      ack_d   = (state_d == S_RECOVER);
      busy_d  = in_bus_c;
      oe_n_d  = !in_data_c;
      we_n_d  = !(in_data_c && wr_d);
      pio_d   = in_bus_c && !io_d;
      oe_hi_d = in_bus_c;
      // Low half turns around to input for reads once DATA starts
      oe_lo_d = in_bus_c && (!in_tail_c || wr_d);
      ad_o_d  = '0;
      if (in_bus_c) begin
         ad_o_d = {addr_d[ADDR_W-1:DATA_W], (in_tail_c && wr_d) ? wdata_d : addr_d[DATA_W-1:0]};
      end
   end

   // All state and outputs registered; reset aborts any cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         io_q     <= 1'b0;
         rdata    <= '0;
         ad_o     <= '0;
         ack      <= 1'b0;
         busy     <= 1'b0;
         ale      <= 1'b0;
         oe_n     <= 1'b1;
         we_n     <= 1'b1;
         pio      <= 1'b0;
         ad_oe_hi <= 1'b0;
         ad_oe_lo <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
         io_q     <= io_d;
         rdata    <= rdata_d;
         ad_o     <= ad_o_d;
         ack      <= ack_d;
         busy     <= busy_d;
         ale      <= ale_d;
         oe_n     <= oe_n_d;
         we_n     <= we_n_d;
         pio      <= pio_d;
         ad_oe_hi <= oe_hi_d;
         ad_oe_lo <= oe_lo_d;
      end
   end

endmodule
